// File: rtl/if_id_fetch_ctrl_if.sv
// if_id_fetch_ctrl_if: hazard-control, redirect, imem and IF/ID signals between the hazard unit/memory side (master) and the fetch controller (slave)
//   master drives: PCWrite, IF_ID_Hold, IF_ID_Flush, PCSrc, branch/jump/jr targets, imem_instr
//   slave drives : pc, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, stall_timeout
//                  stall_cycles, flush_count (only when IF_PERF_CNT_EN is defined)
interface if_id_fetch_ctrl_if;
  logic        PCWrite;
  logic        IF_ID_Hold;
  logic        IF_ID_Flush;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        stall_timeout;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif
  modport master (
    output PCWrite, IF_ID_Hold, IF_ID_Flush, PCSrc, branch_target, jump_target, jr_target, imem_instr,
`ifdef IF_PERF_CNT_EN
    input  stall_cycles, flush_count,
`endif
    input  pc, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, stall_timeout
  );
  modport slave (
    input  PCWrite, IF_ID_Hold, IF_ID_Flush, PCSrc, branch_target, jump_target, jr_target, imem_instr,
`ifdef IF_PERF_CNT_EN
    output stall_cycles, flush_count,
`endif
    output pc, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, stall_timeout
  );
endinterface

// File: rtl/if_id_fetch_ctrl.sv
// if_id_fetch_ctrl: program counter, IF/ID register and stall watchdog driven by hazard-unit controls
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : if_id_fetch_ctrl_if.slave (hazard controls, redirect targets, imem data in; pc and IF/ID out)
//   RESET_PC    : pc after reset
//   STALL_LIMIT : consecutive hold cycles that raise the sticky stall_timeout (1..255)
//   IF_PERF_CNT_EN : when defined, adds saturating stall_cycles and flush_count counters
module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  if_id_fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_t;
  localparam logic [7:0] LIM    = 8'(STALL_LIMIT);
  localparam logic [7:0] LIM_M1 = 8'(STALL_LIMIT - 1);
  logic [31:0] r_pc, r_instr, r_pc_plus4;
  logic        r_valid, r_timeout, w_timeout_nxt;
  logic [31:0] w_pc_plus4, w_target, w_next_pc;
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = bus.PCSrc == 2'b00 ? w_pc_plus4 :
                      bus.PCSrc == 2'b01 ? bus.branch_target :
                      bus.PCSrc == 2'b10 ? bus.jump_target : bus.jr_target;
  // word-align every redirect; low target bits are simply dropped
  assign w_next_pc  = w_target & ~32'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (bus.PCWrite) r_pc <= w_next_pc;
      // hold wins over flush so a stalled instruction is never lost
      if (!bus.IF_ID_Hold) begin
        r_instr    <= bus.IF_ID_Flush ? 32'h0000_0000 : bus.imem_instr;
        r_pc_plus4 <= bus.IF_ID_Flush ? 32'h0000_0000 : w_pc_plus4;
        r_valid    <= !bus.IF_ID_Flush;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  // r_cnt counts consecutive hold cycles; reaching LIM enters TIMEOUT and sets the sticky flag
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      RUN: if (bus.IF_ID_Hold) begin
        w_cnt_nxt = 8'd1;
        if (LIM == 8'd1) begin
          w_state_nxt   = TIMEOUT;
          w_timeout_nxt = 1'b1;
        end else w_state_nxt = STALL;
      end
      STALL: if (bus.IF_ID_Hold) begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == LIM_M1) begin
          w_state_nxt   = TIMEOUT;
          w_timeout_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
      TIMEOUT: if (!bus.IF_ID_Hold) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = LIM;
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end
  assign bus.pc            = r_pc;
  assign bus.IF_ID_Instr   = r_instr;
  assign bus.IF_ID_PCPlus4 = r_pc_plus4;
  assign bus.IF_ID_Valid   = r_valid;
  assign bus.stall_timeout = r_timeout;
`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (bus.IF_ID_Hold && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (bus.IF_ID_Flush && !bus.IF_ID_Hold && r_flush_count != '1) r_flush_count <= r_flush_count + 32'd1;
    end
  end
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb_if_id_fetch_ctrl: directed literal checks plus randomized stimulus compared each cycle against a behavioural model
module tb_if_id_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int LIMIT = 8;
  logic clk = 0;
  logic rst_n = 1;
  int errors = 0;
  int checks = 0;
  if_id_fetch_ctrl_if bus();
  if_id_fetch_ctrl #(.RESET_PC(RPC), .STALL_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction
  assign bus.imem_instr = imem_f(bus.pc);
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  logic [31:0] m_pc, m_instr, m_pp4, m_sc, m_fc;
  logic        m_valid, m_to;
  int          m_run;
  logic [31:0] m_tgt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_instr <= 0; m_pp4 <= 0; m_valid <= 0; m_to <= 0; m_run <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      m_tgt = bus.PCSrc == 0 ? m_pc + 4 : bus.PCSrc == 1 ? bus.branch_target :
              bus.PCSrc == 2 ? bus.jump_target : bus.jr_target;
      if (bus.PCWrite) m_pc <= {m_tgt[31:2], 2'b00};
      if (!bus.IF_ID_Hold) begin
        m_instr <= bus.IF_ID_Flush ? 0 : imem_f(m_pc);
        m_pp4   <= bus.IF_ID_Flush ? 0 : m_pc + 4;
        m_valid <= !bus.IF_ID_Flush;
      end
      m_run <= bus.IF_ID_Hold ? m_run + 1 : 0;
      m_to  <= m_to || (bus.IF_ID_Hold && m_run + 1 >= LIMIT);
      if (bus.IF_ID_Hold && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
      if (bus.IF_ID_Flush && !bus.IF_ID_Hold && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
    end
  end
  always @(negedge clk) begin
    chk("pc", bus.pc, m_pc);
    chk("instr", bus.IF_ID_Instr, m_instr);
    chk("pcplus4", bus.IF_ID_PCPlus4, m_pp4);
    chk("valid", 32'(bus.IF_ID_Valid), 32'(m_valid));
    chk("timeout", 32'(bus.stall_timeout), 32'(m_to));
`ifdef IF_PERF_CNT_EN
    chk("stall_cycles", bus.stall_cycles, m_sc);
    chk("flush_count", bus.flush_count, m_fc);
`endif
  end
  task automatic drive(input logic w, input logic h, input logic f, input logic [1:0] s);
    bus.PCWrite = w; bus.IF_ID_Hold = h; bus.IF_ID_Flush = f; bus.PCSrc = s;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 0; #3 rst_n = 1;
  endtask
  int burst = 0;
  logic [31:0] held;
  initial begin
    drive(1, 0, 0, 0);
    bus.branch_target = 0; bus.jump_target = 0; bus.jr_target = 0;
    #2 rst_n = 0;
    #1 chk("reset_pc", bus.pc, RPC);
    chk("reset_valid", 32'(bus.IF_ID_Valid), 0);
    chk("reset_instr", bus.IF_ID_Instr, 0);
    tick(); tick();
    rst_n = 1;
    chk("idle0_pc", bus.pc, 32'h0040_0000);
    tick();
    chk("idle1_pc", bus.pc, 32'h0040_0004);
    chk("idle1_pp4", bus.IF_ID_PCPlus4, 32'h0040_0004);
    chk("idle1_valid", 32'(bus.IF_ID_Valid), 1);
    tick(); tick();
    chk("idle3_pc", bus.pc, 32'h0040_000C);
    chk("idle3_pp4", bus.IF_ID_PCPlus4, 32'h0040_000C);
    held = bus.IF_ID_Instr;
    drive(0, 1, 0, 0); tick();
    chk("stall_pc", bus.pc, 32'h0040_000C);
    chk("stall_instr", bus.IF_ID_Instr, held);
    drive(1, 0, 0, 0); tick();
    chk("stall_to", 32'(bus.stall_timeout), 0);
    bus.branch_target = 32'h0040_0103; drive(1, 0, 1, 2'b01); tick();
    chk("br_pc", bus.pc, 32'h0040_0100);
    chk("br_instr", bus.IF_ID_Instr, 0);
    chk("br_valid", 32'(bus.IF_ID_Valid), 0);
    drive(1, 0, 0, 0); tick();
    chk("br_load", bus.IF_ID_Instr, imem_f(32'h0040_0100));
    held = bus.IF_ID_Instr;
    drive(0, 1, 1, 0); tick();
    chk("hf_instr", bus.IF_ID_Instr, held);
    chk("hf_valid", 32'(bus.IF_ID_Valid), 1);
`ifdef IF_PERF_CNT_EN
    chk("hf_fc", bus.flush_count, 1);
`endif
    drive(0, 0, 0, 0); do_reset(); drive(0, 1, 0, 0);
    for (int i = 1; i <= LIMIT; i++) begin
      tick();
      chk($sformatf("wd_to_%0d", i), 32'(bus.stall_timeout), i == LIMIT ? 1 : 0);
    end
    drive(1, 0, 0, 0); tick();
    chk("wd_sticky", 32'(bus.stall_timeout), 1);
`ifdef IF_PERF_CNT_EN
    chk("wd_sc", bus.stall_cycles, 8);
`endif
    bus.jr_target = 32'hFFFF_FFFE; drive(1, 0, 0, 2'b11); tick();
    chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0); tick();
    chk("wrap_pc", bus.pc, 0);
    chk("wrap_pp4", bus.IF_ID_PCPlus4, 0);
    chk("wrap_to", 32'(bus.stall_timeout), 1);
    #2 rst_n = 0;
    #1 chk("async_pc", bus.pc, RPC);
    chk("async_valid", 32'(bus.IF_ID_Valid), 0);
    chk("async_to", 32'(bus.stall_timeout), 0);
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 12);
      bus.IF_ID_Hold = burst > 0 ? 1'b1 : ($urandom_range(0, 4) == 0);
      if (burst > 0) burst--;
      bus.PCWrite = bus.IF_ID_Hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      bus.IF_ID_Flush = $urandom_range(0, 3) == 0;
      bus.PCSrc = 2'($urandom_range(0, 3));
      bus.branch_target = $urandom; bus.jump_target = $urandom; bus.jr_target = $urandom;
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
